// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word, RAM port status and memory arbiter grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter between the L1 caches and the single RAM port.
// The data side has priority over the instruction side. Two-word blocks stay
// locked to the data side. A saturating starvation counter forces an
// instruction grant after STARVE_MAX data words completed while iREN waited.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ARB_IDLE  | no grant; pick the next owner (data first unless fetch starved)
//   ARB_DATA  | dcache owns RAM; stays granted after an even word (pair lock)
//   ARB_INSTR | icache owns RAM until its word completes or iREN drops
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ram_err
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          d_req, ram_acc, d_done, i_done, starved;

  assign d_req   = dREN | dWEN;
  assign ram_acc = (ramstate == ACCESS);
  assign d_done  = (state == ARB_DATA) && d_req && ram_acc;
  assign i_done  = (state == ARB_INSTR) && ram_acc;
  assign starved = iREN && (starve_cnt == CW'(STARVE_MAX));

  // Both caches see the RAM read data directly; wait tells them when it is theirs.
  assign iload = ramload;
  assign dload = ramload;

  // Grant register: the only record of who owns the RAM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Count data words finished while fetch waits; any idle fetch or served fetch clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                       starve_cnt <= '0;
    else if (!iREN || i_done)                        starve_cnt <= '0;
    else if (d_done && starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
  end

  // Sticky RAM error flag, only meaningful while someone holds the grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                    ram_err <= 1'b0;
    else if (state != ARB_IDLE && ramstate == ERROR) ram_err <= 1'b1;
  end

  // Next grant and RAM/cache handshake outputs for the current owner.
  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && !starved) state_nxt = ARB_DATA;
        else if (iREN)         state_nxt = ARB_INSTR;
      end
      ARB_DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (d_req) begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          dwait  = ~ram_acc;
          if (ram_acc && daddr[2]) state_nxt = ARB_IDLE;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_INSTR: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~ram_acc;
        if (ram_acc || !iREN) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reactive cache/RAM stimulus, an
// owner-level reference model checked every cycle, and literal pins per scenario.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, ram_err;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          we;
    bit          gap;
  } dreq_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dreq_t       dq[$];
  logic [31:0] iq[$];
  logic [31:0] dlog_addr[$];
  int          dlog_cyc[$];
  int          ilog_cyc[$];

  bit          auto_drv = 1'b1;
  bit          d_gap = 1'b0;
  bit          force_err = 1'b0;
  int          ram_lat = 1;
  int          ram_age = 0;
  logic        m_iREN = 1'b0, m_dREN = 1'b0, m_dWEN = 1'b0;
  word_t       m_iaddr = '0, m_daddr = '0, m_dstore = '0;

  // reference model: who owns the RAM (0 none, 1 data, 2 instr), starvation count, error flag
  int owner = 0;
  int starve = 0;
  bit err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; starve = 0; err = 1'b0;
  endtask

  task automatic compare_model();
    logic e_rr, e_rw, e_iw, e_dw;
    word_t e_a, e_s;
    bit acc, req;
    acc = (ramstate == ACCESS);
    req = dREN | dWEN;
    e_rr = 0; e_rw = 0; e_iw = 1; e_dw = 1; e_a = '0; e_s = '0;
    if (owner == 1) begin
      e_a = daddr; e_s = dstore;
      if (req) begin
        e_rw = dWEN; e_rr = dREN & ~dWEN; e_dw = !acc;
      end
    end else if (owner == 2) begin
      e_rr = iREN; e_a = iaddr; e_iw = !acc;
    end
    chk("ramREN", ramREN, e_rr);
    chk("ramWEN", ramWEN, e_rw);
    chk("ramaddr", ramaddr, e_a);
    chk("ramstore", ramstore, e_s);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    chk("ram_err", ram_err, err);
    chk("starve_cnt", 32'(dut.starve_cnt), starve);
  endtask

  task automatic model_advance();
    bit acc, req, dd, id;
    int nxt;
    if (!nRST) begin
      model_reset();
      return;
    end
    acc = (ramstate == ACCESS);
    req = dREN | dWEN;
    dd  = (owner == 1) && req && acc;
    id  = (owner == 2) && acc;
    if (owner != 0 && ramstate == ERROR) err = 1'b1;
    nxt = owner;
    case (owner)
      0: if (req && !(iREN && starve == SMAX)) nxt = 1; else if (iREN) nxt = 2;
      1: if (!req || (acc && daddr[2])) nxt = 0;
      default: if (acc || !iREN) nxt = 0;
    endcase
    if (!iREN || id) starve = 0;
    else if (dd && starve < SMAX) starve = starve + 1;
    owner = nxt;
  endtask

  task automatic cycle();
    bit strobe, g;
    dreq_t h;
    @(negedge CLK);
    if (auto_drv) begin
      g = d_gap;
      d_gap = 1'b0;
      if (g || dq.size() == 0) begin
        dREN = 0; dWEN = 0;
      end else begin
        h = dq[0];
        dREN = !h.we; dWEN = h.we; daddr = h.addr; dstore = h.data;
      end
      iREN = (iq.size() != 0);
      if (iREN) iaddr = iq[0];
    end else begin
      iREN = m_iREN; iaddr = m_iaddr;
      dREN = m_dREN; dWEN = m_dWEN; daddr = m_daddr; dstore = m_dstore;
    end
    #1;
    strobe = ramREN | ramWEN;
    if (force_err)                          ramstate = ERROR;
    else if (strobe && ram_age >= ram_lat) ramstate = ACCESS;
    else if (strobe)                        ramstate = BUSY;
    else                                    ramstate = FREE;
    ramload = {ramaddr[15:0], ~ramaddr[15:0]};
    #1;
    compare_model();
    if (nRST) begin
      if (dwait == 1'b0 && (dREN | dWEN)) begin
        dlog_addr.push_back(daddr);
        dlog_cyc.push_back(cyc);
        if (auto_drv && dq.size() != 0) begin
          h = dq.pop_front();
          d_gap = h.gap;
        end
      end
      if (iwait == 1'b0) begin
        ilog_cyc.push_back(cyc);
        if (auto_drv && iq.size() != 0) void'(iq.pop_front());
      end
    end
    if (!nRST || !strobe || ramstate == ACCESS) ram_age = 0;
    else                                        ram_age = ram_age + 1;
    model_advance();
    cyc++;
  endtask

  task automatic clear_logs();
    dlog_addr.delete(); dlog_cyc.delete(); ilog_cyc.delete();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((dq.size() != 0 || iq.size() != 0 || d_gap) && n < budget) begin
      cycle();
      n++;
    end
    chk("queue_drain_in_budget", n < budget, 1);
    repeat (2) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) cycle();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ram_err", ram_err, 0);
    nRST = 1;
    cycle();

    // 1: read pair 0x40/0x44, second word follows without an idle bubble
    clear_logs();
    dq.push_back('{32'h40, 32'h0, 1'b0, 1'b0});
    dq.push_back('{32'h44, 32'h0, 1'b0, 1'b0});
    run_until_empty(40);
    chk("t1_words", dlog_addr.size(), 2);
    if (dlog_addr.size() == 2) begin
      chk("t1_addr0", dlog_addr[0], 32'h40);
      chk("t1_addr1", dlog_addr[1], 32'h44);
      chk("t1_gap_cycles", dlog_cyc[1] - dlog_cyc[0], 2);
    end
    chk("t1_idle_after", dut.state == ARB_IDLE, 1);

    // 2: simultaneous write pair and fetch, data first
    clear_logs();
    dq.push_back('{32'h80, 32'hDEADBEEF, 1'b1, 1'b0});
    dq.push_back('{32'h84, 32'hCAFEF00D, 1'b1, 1'b0});
    iq.push_back(32'h100);
    run_until_empty(60);
    chk("t2_order", (ilog_cyc.size() == 1 && dlog_cyc.size() == 2 && ilog_cyc[0] > dlog_cyc[1]), 1);

    // 3: fetch starved by single reads, forced after four data words
    clear_logs();
    iq.push_back(32'h104);
    for (int k = 0; k < 6; k++) dq.push_back('{32'h10 + 32'(k * 8), 32'h0, 1'b0, 1'b1});
    run_until_empty(120);
    n = 0;
    foreach (dlog_cyc[k]) if (ilog_cyc.size() > 0 && dlog_cyc[k] < ilog_cyc[0]) n++;
    chk("t3_words_before_fetch", n, 4);
    chk("t3_starve_cleared", 32'(dut.starve_cnt), 0);

    // 4: starvation limit reached on the even word of a writeback pair
    clear_logs();
    iq.push_back(32'h108);
    dq.push_back('{32'h10, 32'h0, 1'b0, 1'b1});
    dq.push_back('{32'h18, 32'h0, 1'b0, 1'b1});
    dq.push_back('{32'h20, 32'h0, 1'b0, 1'b1});
    dq.push_back('{32'h40, 32'h11111111, 1'b1, 1'b0});
    dq.push_back('{32'h44, 32'h22222222, 1'b1, 1'b0});
    dq.push_back('{32'h60, 32'h0, 1'b0, 1'b1});
    run_until_empty(120);
    chk("t4_words", dlog_addr.size(), 6);
    if (dlog_addr.size() == 6 && ilog_cyc.size() == 1) begin
      chk("t4_addr4", dlog_addr[4], 32'h44);
      chk("t4_addr5", dlog_addr[5], 32'h60);
      chk("t4_fetch_between", (ilog_cyc[0] > dlog_cyc[4]) && (ilog_cyc[0] < dlog_cyc[5]), 1);
    end

    // 5a: RAM error during instruction grant
    auto_drv = 0;
    m_iREN = 1; m_iaddr = 32'h200;
    force_err = 1;
    repeat (4) cycle();
    chk("t5_err_set", ram_err, 1);
    chk("t5_err_iwait", iwait, 1);
    force_err = 0;
    n = 0;
    while (iwait !== 1'b0 && n < 10) begin
      cycle();
      n++;
    end
    chk("t5_fetch_done", iwait, 0);
    m_iREN = 0;
    repeat (2) cycle();
    chk("t5_err_sticky", ram_err, 1);

    // 5b: data read dropped while RAM is still busy
    ram_lat = 5;
    m_dREN = 1; m_daddr = 32'h300;
    repeat (3) cycle();
    chk("t5_abort_strobe_before", ramREN, 1);
    m_dREN = 0;
    cycle();
    chk("t5_abort_ramREN", ramREN, 0);
    chk("t5_abort_dwait", dwait, 1);
    cycle();
    chk("t5_abort_idle", dut.state == ARB_IDLE, 1);

    // 6: asynchronous reset in the middle of a write grant
    auto_drv = 1;
    clear_logs();
    dq.push_back('{32'h500, 32'h0000ABCD, 1'b1, 1'b1});
    repeat (2) cycle();
    chk("t6_write_active", ramWEN, 1);
    nRST = 0;
    #1;
    chk("t6_rst_ramWEN", ramWEN, 0);
    chk("t6_rst_dwait", dwait, 1);
    chk("t6_rst_iwait", iwait, 1);
    chk("t6_rst_ram_err", ram_err, 0);
    model_reset();
    dq.delete();
    d_gap = 0;
    ram_age = 0;
    repeat (2) cycle();
    nRST = 1;
    ram_lat = 1;
    clear_logs();
    dq.push_back('{32'h508, 32'h0, 1'b0, 1'b0});
    run_until_empty(40);
    chk("t6_fresh_words", dlog_addr.size(), 1);
    if (dlog_addr.size() == 1) chk("t6_fresh_addr", dlog_addr[0], 32'h508);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Registered arbiter between the L1 caches and the single RAM port; sits directly downstream of the data cache's cif bus and the instruction cache.
- Grants the RAM to one requester at a time and locks the data side for two-word block transfers (fill, writeback, flush).
- Data side has priority; a bounded starvation counter guarantees forward progress for instruction fetch.
- Returns wait and load data to the caches.

Parameters:
- STARVE_MAX, 4: consecutive completed data words with iREN pending before instruction fetch is forced ahead of data.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for the one cycle an instruction word completes
- iload  out  32  instruction data, equals ramload
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for the one cycle a data word completes
- dload  out  32  data load, equals ramload
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_err  out  1  sticky; set when ramstate==ERROR while granted

Behaviour:
- Reset values:
  - state=ARB_IDLE, starve_cnt=0, ram_err=0.
  - Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- The state register is the only grant; RAM outputs are combinational from state and the granted requester's inputs.
- ARB_IDLE:
  - No RAM strobes; ramaddr=0, ramstore=0; both waits high.
  - Next state:
    - (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX) -> ARB_DATA.
    - else iREN -> ARB_INSTR.
    - else stay.
- ARB_DATA:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN. If both are asserted, the write wins.
  - dwait = ~(ramstate==ACCESS).
  - On ACCESS with daddr[2]==0: stay in ARB_DATA (pair lock) so the second word follows with no idle cycle.
  - On ACCESS with daddr[2]==1: go to ARB_IDLE.
  - If dREN=dWEN=0 while in ARB_DATA: no strobes, dwait=1, go to ARB_IDLE next cycle. This covers an aborted or finished pair.
- ARB_INSTR:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - iwait = ~(ramstate==ACCESS).
  - On ACCESS, or if iREN drops: go to ARB_IDLE.
- Latency: request seen in cycle N, grant in N+1, earliest completion (wait low) in N+1. Back-to-back single-word requests have one ARB_IDLE bubble between grants.
- starve_cnt (width $clog2(STARVE_MAX+1)):
  - Increments on each completed data word while iREN=1; saturates at STARVE_MAX.
  - Cleared when an instruction word completes or when iREN=0.
  - A forced instruction grant is taken only from ARB_IDLE. It never breaks a data pair lock.
- ramstate FREE or BUSY while granted: hold the grant and keep the requester's wait high.
- ramstate ERROR while granted: set ram_err. Hold the grant with the requester's wait high.
- The non-granted requester's wait is always 1; its inputs are ignored.
- Reset asserted mid-transaction: return to ARB_IDLE immediately and drop strobes asynchronously. No partial pair is retained.

Decomposition:
- cpu_types_pkg supplies ramstate_t and word_t.
- Add arb_state_t {ARB_IDLE, ARB_DATA, ARB_INSTR} to cpu_types_pkg.
- Single module; starve_cnt is inline, so no sub-module.

Test Plan:
1. Read pair: dREN=1, daddr=0x40, then 0x44; RAM gives ACCESS one cycle after each strobe. -> ramREN=1 with ramaddr 0x40 then 0x44 and no ARB_IDLE between them; dwait low twice; dload follows ramload; then ARB_IDLE.
2. Simultaneous requests: iREN=1 (iaddr=0x100) and dWEN=1 (daddr=0x80, dstore=0xDEADBEEF) in the same cycle. -> data granted first: ramWEN=1, ramstore=0xDEADBEEF. Instruction is served after the 0x80/0x84 pair; iwait stays 1 until then.
3. Starvation: iREN held, dcache issues continuous single reads at 0x10, 0x18, 0x20… -> after 4 completed data words, next ARB_IDLE grants ARB_INSTR; starve_cnt returns to 0 after iwait goes low.
4. Pair lock versus starvation: starve_cnt=4 reached on the 0x40 word of a writeback pair. -> 0x44 completes before the instruction grant.
5. ERROR and abort: ramstate=ERROR during ARB_INSTR. -> ram_err=1 stays set, iwait=1. Separately, dREN dropped mid-grant -> strobes fall, ARB_IDLE next cycle.
6. Reset: nRST low while in ARB_DATA with ramWEN=1. -> ramWEN=0 immediately, dwait=1, iwait=1, ram_err=0; after release, a fresh request is granted normally.
